dct_mem_ctrl: RTL and testbench



---
 rtl/dct_mem_ctrl_pkg.sv | 18 +
 rtl/dct_mem_ctrl.sv | 133 +++++++++++++
 tb/tb_dct_mem_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_mem_ctrl_pkg.sv
// Shared definitions for the DCT sample-memory load sequencer: default sample
// format, frame size and controller state encoding.
package dct_mem_ctrl_pkg;

  localparam int unsigned DctN = 23;               // mantissa width
  localparam int unsigned DctM = 8;                // exponent width
  localparam int unsigned DctL = DctN + DctM + 1;  // sign + exponent + mantissa
  localparam int unsigned DctK = 16;               // samples per frame

  typedef enum logic [2:0] {
    StClear,
    StLoad,
    StLast,
    StGo,
    StWait
  } state_e;

endpackage

// File: rtl/dct_mem_ctrl.sv
// Load sequencer: writes exactly K contiguous samples into the DCT input memory,
// pulses the engine start, then holds off the next frame until the engine is done.
module dct_mem_ctrl
  import dct_mem_ctrl_pkg::*;
#(
  parameter int unsigned N = DctN,
  parameter int unsigned M = DctM,
  parameter int unsigned L = N + M + 1,
  parameter int unsigned K = DctK
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [L-1:0] in_data,
  output logic         in_ready,
  output logic         mem_reset,
  output logic         mem_start,
  output logic [L-1:0] mem_inp,
  output logic         dct_start,
  input  logic         dct_done,
  output logic         busy,
  output logic         err_gap,
  output logic [15:0]  frame_cnt
);

  localparam int unsigned IdxW = $clog2(K);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(K - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            mem_start_q, mem_start_d;
  logic [L-1:0]    mem_inp_q, mem_inp_d;
  logic            err_gap_q, err_gap_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            dct_start_q, dct_start_d;
  logic            busy_q, busy_d;
  logic            xfer;

  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mem_start_d = mem_start_q;
    mem_inp_d   = mem_inp_q;
    err_gap_d   = err_gap_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      StClear: begin
        state_d     = StLoad;
        idx_d       = '0;
        mem_start_d = 1'b0;
      end
      StLoad: begin
        if (xfer) begin
          mem_start_d = 1'b1;
          mem_inp_d   = in_data;
          idx_d       = idx_q + IdxW'(1);
          if (idx_q == IdxLast) begin
            state_d = StLast;
          end
        end else begin
          mem_start_d = 1'b0;
          // A gap mid-frame would desynchronise the memory's write counter.
          if (idx_q != '0) begin
            err_gap_d = 1'b1;
            idx_d     = '0;
            state_d   = StClear;
          end
        end
      end
      StLast: begin
        mem_start_d = 1'b0;
        state_d     = StGo;
      end
      StGo: begin
        state_d = StWait;
      end
      StWait: begin
        if (dct_done) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = StClear;
        end
      end
      default: begin
        state_d = StClear;
        idx_d   = '0;
      end
    endcase

    // Handshake/status flags are registered alongside the state they decode.
    in_ready_d  = (state_d == StLoad);
    dct_start_d = (state_d == StGo);
    busy_d      = (state_d == StLast) || (state_d == StGo) || (state_d == StWait) ||
                  ((state_d == StLoad) && (idx_d != '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StClear;
      idx_q       <= '0;
      mem_start_q <= 1'b0;
      mem_inp_q   <= '0;
      err_gap_q   <= 1'b0;
      frame_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      dct_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mem_start_q <= mem_start_d;
      mem_inp_q   <= mem_inp_d;
      err_gap_q   <= err_gap_d;
      frame_cnt_q <= frame_cnt_d;
      in_ready_q  <= in_ready_d;
      dct_start_q <= dct_start_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_reset = !reset_n || (state_q == StClear);
  assign in_ready  = in_ready_q;
  assign mem_start = mem_start_q;
  assign mem_inp   = mem_inp_q;
  assign dct_start = dct_start_q;
  assign busy      = busy_q;
  assign err_gap   = err_gap_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dct_mem_ctrl.sv
// Bench for dct_mem_ctrl: frame-level reference model plus a model of the sample
// memory, compared against the DUT on every falling edge.
module tb_dct_mem_ctrl;
  import dct_mem_ctrl_pkg::*;

  localparam int unsigned L = DctL;
  localparam int unsigned K = DctK;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [L-1:0] in_data = '0;
  logic         dct_done = 1'b0;
  logic         in_ready, mem_reset, mem_start, dct_start, busy, err_gap;
  logic [L-1:0] mem_inp;
  logic [15:0]  frame_cnt;

  dct_mem_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_reset(mem_reset),
    .mem_start(mem_start),
    .mem_inp  (mem_inp),
    .dct_start(dct_start),
    .dct_done (dct_done),
    .busy     (busy),
    .err_gap  (err_gap),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level model: samples accepted so far, cycles since the frame filled.
  bit           m_clr;
  int           m_cnt;
  int           m_tail;
  bit           m_xfer;
  bit           m_prev;
  logic [L-1:0] m_data;
  bit           m_err;
  int           m_frames;
  logic [L-1:0] m_frame [K];

  // Sample memory as seen by the datapath: captures on the falling edge.
  logic [L-1:0] arr [K];
  int           ptr = 0;

  int cyc_no = 0;
  int first_acc = 0;
  int go_cyc = 0;
  int go_count = 0;
  int go_hist [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clr = 1'b1; m_cnt = 0; m_tail = 0; m_xfer = 1'b0; m_prev = 1'b0;
    m_data = '0; m_err = 1'b0; m_frames = 0;
  endtask

  task automatic model_step();
    m_xfer = in_valid && !m_clr && (m_cnt < int'(K));
    if (m_clr) begin
      m_clr  = 1'b0;
      m_prev = 1'b0;
    end else if (m_cnt < int'(K)) begin
      if (m_xfer) begin
        m_frame[m_cnt] = in_data;
        m_cnt++;
        m_data = in_data;
        if (m_cnt == int'(K)) m_tail = 1;
      end else if (m_cnt > 0) begin
        m_err = 1'b1;
        m_clr = 1'b1;
        m_cnt = 0;
      end
      m_prev = m_xfer;
    end else begin
      m_prev = 1'b0;
      if (m_tail >= 3 && dct_done) begin
        m_frames = (m_frames + 1) % 65536;
        m_clr    = 1'b1;
        m_cnt    = 0;
        m_tail   = 0;
      end else if (m_tail < 100) begin
        m_tail++;
      end
    end
  endtask

  // Compare process.
  initial forever begin
    @(negedge clk);
    if (mem_reset) begin
      ptr = 0;
    end else if (mem_start) begin
      if (ptr < int'(K)) arr[ptr] = mem_inp;
      else chk("mem_overrun", 64'(ptr), 64'(K - 1));
      ptr++;
    end
    chk("in_ready", 64'(in_ready), 64'(!m_clr && m_cnt < int'(K)));
    chk("mem_reset", 64'(mem_reset), 64'(m_clr || !reset_n));
    chk("mem_start", 64'(mem_start), 64'(m_prev));
    chk("mem_inp", 64'(mem_inp), 64'(m_data));
    chk("dct_start", 64'(dct_start), 64'(m_tail == 2));
    chk("busy", 64'(busy), 64'(m_cnt > 0 && !m_clr));
    chk("err_gap", 64'(err_gap), 64'(m_err));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_frames));
    if (m_tail == 2) begin
      go_cyc = cyc_no;
      go_count++;
      chk("mem_fill", 64'(ptr), 64'(K));
      for (int i = 0; i < int'(K); i++) chk("mem_slot", 64'(arr[i]), 64'(m_frame[i]));
    end
  end

  task automatic cyc(input bit v, input logic [L-1:0] d, input bit done);
    in_valid = v;
    in_data  = d;
    dct_done = done;
    @(posedge clk);
    cyc_no++;
    if (reset_n) model_step();
    #1;
  endtask

  task automatic send(input logic [L-1:0] d, input bit done);
    int tries = 0;
    do begin
      cyc(1'b1, d, done);
      tries++;
    end while (!m_xfer && tries < 8);
    if (!m_xfer) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_samples(input int n, input logic [L-1:0] base, input bit rnd,
                              input bit done);
    for (int i = 0; i < n; i++) begin
      send(rnd ? L'($urandom) : base + L'(i), done);
      if (i == 0) first_acc = cyc_no;
    end
  endtask

  // From LAST: GO, then w cycles of WAIT, then dct_done.
  task automatic finish_frame(input int w);
    repeat (w + 1) cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L-1:0] one;
    int g;
    one = 32'h3F80_0000;
    model_reset();
    #22;
    chk("rst_mem_reset_lit", 64'(mem_reset), 64'(1));
    chk("rst_in_ready_lit", 64'(in_ready), 64'(0));
    chk("rst_frame_cnt_lit", 64'(frame_cnt), 64'(0));
    reset_n = 1'b1;

    // Contiguous frame of 1.0 + i ulp.
    send_samples(int'(K), one, 1'b0, 1'b0);
    finish_frame(2);
    chk("latency_lit", 64'(go_cyc - first_acc), 64'(16));
    for (int i = 0; i < int'(K); i++) chk("slot_lit", 64'(arr[i]), 64'(one + L'(i)));
    chk("frames1_lit", 64'(frame_cnt), 64'(1));
    chk("go_count1_lit", 64'(go_count), 64'(1));

    // Idle wait before the first sample.
    repeat (6) cyc(1'b0, L'($urandom), 1'b0);
    chk("idle_err_lit", 64'(err_gap), 64'(0));
    chk("idle_start_lit", 64'(mem_start), 64'(0));
    send_samples(int'(K), '0, 1'b1, 1'b0);
    finish_frame(3);
    chk("frames2_lit", 64'(frame_cnt), 64'(2));

    // Gap after 7 samples aborts the frame.
    g = go_count;
    send_samples(7, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("gap_err_lit", 64'(err_gap), 64'(1));
    chk("gap_clear_lit", 64'(mem_reset), 64'(1));
    chk("gap_no_go_lit", 64'(go_count), 64'(g));
    send_samples(int'(K), '0, 1'b1, 1'b0);
    finish_frame(1);
    chk("gap_go_lit", 64'(go_count), 64'(g + 1));
    chk("frames3_lit", 64'(frame_cnt), 64'(3));

    // dct_done during LOAD, LAST and GO is ignored.
    send_samples(int'(K), '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("done_ignored_lit", 64'(frame_cnt), 64'(3));
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("frames4_lit", 64'(frame_cnt), 64'(4));
    chk("clear_after_done_lit", 64'(mem_reset), 64'(1));

    // Asynchronous reset mid-LOAD.
    g = go_count;
    send_samples(10, '0, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_mem_reset_lit", 64'(mem_reset), 64'(1));
    chk("arst_mem_start_lit", 64'(mem_start), 64'(0));
    chk("arst_in_ready_lit", 64'(in_ready), 64'(0));
    chk("arst_busy_lit", 64'(busy), 64'(0));
    chk("arst_err_lit", 64'(err_gap), 64'(0));
    chk("arst_frames_lit", 64'(frame_cnt), 64'(0));
    chk("arst_mem_inp_lit", 64'(mem_inp), 64'(0));
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    chk("arst_no_go_lit", 64'(go_count), 64'(g));
    send_samples(int'(K), '0, 1'b1, 1'b0);
    finish_frame(2);
    chk("arst_frames1_lit", 64'(frame_cnt), 64'(1));

    // Three back-to-back frames with a 4-cycle WAIT.
    for (int f = 0; f < 3; f++) begin
      send_samples(int'(K), '0, 1'b1, 1'b0);
      finish_frame(4);
      go_hist[f] = go_cyc;
    end
    chk("b2b_period0_lit", 64'(go_hist[1] - go_hist[0]), 64'(23));
    chk("b2b_period1_lit", 64'(go_hist[2] - go_hist[1]), 64'(23));
    chk("b2b_frames_lit", 64'(frame_cnt), 64'(4));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 96, L'($urandom), $urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
